// File: rtl/audio_pkg.sv
// Shared definitions for the on-board PDM audio path (speaker and microphone).
package audio_pkg;

  localparam int PDM_CLK_DIV    = 40;
  localparam int PDM_OSR        = 64;
  localparam int AUDIO_SAMPLE_W = 16;

  typedef logic signed [AUDIO_SAMPLE_W-1:0] pcm_sample_t;

  // Flipping the sign bit maps two's complement onto offset binary:
  // most negative -> 0, zero -> mid-scale, most positive -> all ones.
  function automatic logic [AUDIO_SAMPLE_W-1:0] to_offset_binary(input pcm_sample_t s);
    return {~s[AUDIO_SAMPLE_W-1], s[AUDIO_SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/sigma_delta_mod.sv
// First-order sigma-delta modulator: one output bit per tick, density
// proportional to the offset-binary value of the active sample.
module sigma_delta_mod
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = AUDIO_SAMPLE_W
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                tick,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                pdm_bit
);

  localparam logic [SAMPLE_W-1:0] SIGN_FLIP = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W-1:0] level;
  logic [SAMPLE_W:0]   sum;

  // Offset-binary level and the one-bit-wider sum whose carry is the PDM bit.
  always_comb begin
    level = sample ^ SIGN_FLIP;
    sum   = {1'b0, acc} + {1'b0, level};
  end

  // Accumulator keeps its residue across sample changes; only clear empties it.
  always_ff @(posedge clock) begin
    if (clear) begin
      acc     <= '0;
      pdm_bit <= 1'b0;
    end else if (tick) begin
      acc     <= sum[SAMPLE_W-1:0];
      pdm_bit <= sum[SAMPLE_W];
    end
  end

endmodule

// File: rtl/pdm_speaker.sv
// PCM-to-PDM speaker output: one-deep sample buffer, PDM bit-clock divider,
// frame counter and a first-order sigma-delta modulator.
module pdm_speaker
  import audio_pkg::*;
#(
  parameter int CLK_DIV  = PDM_CLK_DIV,
  parameter int OSR      = PDM_OSR,
  parameter int SAMPLE_W = AUDIO_SAMPLE_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                pdm_clk,
  output logic                audio_pdm,
  output logic                audio_sd,
  output logic                underrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(OSR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] active;
  logic [SAMPLE_W-1:0] hold;
  logic                hold_full;
  logic                clear;
  logic                tick;
  logic                frame_end;
  logic                accept;

  // Reset and mute share one clear path so a re-enable always starts clean.
  always_comb begin
    clear        = reset || !enable;
    tick         = (div_cnt == DIV_LAST);
    frame_end    = tick && (bit_cnt == BIT_LAST);
    sample_ready = !reset && enable && !hold_full;
    accept       = sample_valid && sample_ready && !frame_end;
  end

  // Bit-clock divider; pdm_clk is a registered compare for a glitch-free pin.
  always_ff @(posedge clock) begin
    if (clear) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
      pdm_clk <= (div_cnt >= DIV_HALF);
    end
  end

  // Frame counter: OSR PDM bits per PCM sample.
  always_ff @(posedge clock) begin
    if (clear) begin
      bit_cnt <= '0;
    end else if (tick) begin
      bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_ONE;
    end
  end

  // Sample buffer: frame-end loads hold first, then a bypassed offer, else repeats.
  always_ff @(posedge clock) begin
    if (clear) begin
      active    <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (frame_end) begin
        if (hold_full) begin
          active    <= hold;
          hold_full <= 1'b0;
        end else if (sample_valid) begin
          active <= sample_data;
        end else begin
          underrun <= 1'b1;
        end
      end
      if (accept) begin
        hold      <= sample_data;
        hold_full <= 1'b1;
      end
    end
  end

  // Amplifier shutdown follows enable with one cycle of delay.
  always_ff @(posedge clock) begin
    if (reset) begin
      audio_sd <= 1'b0;
    end else begin
      audio_sd <= enable;
    end
  end

  sigma_delta_mod #(
    .SAMPLE_W(SAMPLE_W)
  ) u_mod (
    .clock  (clock),
    .clear  (clear),
    .tick   (tick),
    .sample (active),
    .pdm_bit(audio_pdm)
  );

endmodule

// File: tb/tb_pdm_speaker.sv
// Self-checking bench for pdm_speaker with a queue/arithmetic reference model.
module tb_pdm_speaker;

  localparam int CD = 4;
  localparam int OS = 8;
  localparam int W  = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] sample_data = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready;
  logic         pdm_clk;
  logic         audio_pdm;
  logic         audio_sd;
  logic         underrun;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int   m_cycle;
  int   m_acc;
  int   m_cur;
  int   m_q[$];
  logic m_pdm = 1'b0;
  logic m_under = 1'b0;
  logic m_sd = 1'b0;
  logic m_tick = 1'b0;

  // 10 ns system clock.
  always #5 clock = ~clock;

  pdm_speaker #(
    .CLK_DIV (CD),
    .OSR     (OS),
    .SAMPLE_W(W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .pdm_clk     (pdm_clk),
    .audio_pdm   (audio_pdm),
    .audio_sd    (audio_sd),
    .underrun    (underrun)
  );

  // Behavioural model: samples accepted go into a queue; each frame boundary
  // pops the next sample or repeats the last one; bits come from integer math.
  always @(posedge clock) begin : model
    if (reset || !enable) begin
      m_cycle = 0;
      m_acc   = 0;
      m_cur   = 0;
      m_q.delete();
      m_pdm   = 1'b0;
      m_under = 1'b0;
      m_tick  = 1'b0;
      m_sd    = 1'b0;
    end else begin
      m_sd    = 1'b1;
      m_under = 1'b0;
      m_tick  = 1'b0;
      if (sample_valid && m_q.size() == 0) m_q.push_back(int'($signed(sample_data)));
      if (m_cycle % CD == CD - 1) begin
        m_tick = 1'b1;
        m_acc  = m_acc + m_cur + 32768;
        m_pdm  = (m_acc >= 65536);
        m_acc  = m_acc % 65536;
        if ((m_cycle / CD) % OS == OS - 1) begin
          if (m_q.size() > 0) m_cur = m_q.pop_front();
          else m_under = 1'b1;
        end
      end
      m_cycle++;
    end
  end

  task automatic pulse_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    sample_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (audio_pdm !== 1'b0) begin failures++; $display("[TB] FAIL reset_pdm: got %b expected 0", audio_pdm); end
    checks++; if (audio_sd !== 1'b0) begin failures++; $display("[TB] FAIL reset_sd: got %b expected 0", audio_sd); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
    checks++; if (pdm_clk !== 1'b0) begin failures++; $display("[TB] FAIL reset_pdm_clk: got %b expected 0", pdm_clk); end
    checks++; if (sample_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", sample_ready); end
  endtask

  task automatic test_silence();
    int unders;
    int highs;
    int nt;
    logic exp_ready;
    unders = 0; highs = 0; nt = 0;
    @(posedge clock);
    #1 enable = 1'b0; reset = 1'b0;
    @(posedge clock);
    #1 enable = 1'b1;
    @(negedge clock);
    checks++; if (audio_sd !== 1'b0) begin failures++; $display("[TB] FAIL silence_sd_before: got %b expected 0", audio_sd); end
    for (int c = 0; c < 96; c++) begin
      @(negedge clock);
      exp_ready = !reset && enable && (m_q.size() == 0);
      if (c == 0) begin
        checks++; if (audio_sd !== 1'b1) begin failures++; $display("[TB] FAIL silence_sd_after: got %b expected 1", audio_sd); end
      end
      checks++; if (audio_pdm !== m_pdm) begin failures++; $display("[TB] FAIL silence_pdm c=%0d: got %b expected %b", c, audio_pdm, m_pdm); end
      checks++; if (underrun !== m_under) begin failures++; $display("[TB] FAIL silence_underrun c=%0d: got %b expected %b", c, underrun, m_under); end
      checks++; if (sample_ready !== exp_ready) begin failures++; $display("[TB] FAIL silence_ready c=%0d: got %b expected %b", c, sample_ready, exp_ready); end
      if (m_tick) begin
        checks++; if (audio_pdm !== nt[0]) begin failures++; $display("[TB] FAIL silence_pattern tick=%0d: got %b expected %b", nt, audio_pdm, nt[0]); end
        nt++;
      end
      if (underrun === 1'b1) unders++;
      if (pdm_clk === 1'b1) highs++;
    end
    checks++; if (unders != 3) begin failures++; $display("[TB] FAIL silence_underrun_count: got %0d expected 3", unders); end
    checks++; if (highs != 48) begin failures++; $display("[TB] FAIL pdm_clk_duty: got %0d high of 96 expected 48", highs); end
  endtask

  task automatic test_min_scale();
    int unders;
    int ones;
    unders = 0; ones = 0;
    @(posedge clock);
    #1 sample_valid = 1'b1; sample_data = 16'h8000;
    for (int c = 0; c < 160; c++) begin
      @(negedge clock);
      checks++; if (audio_pdm !== m_pdm) begin failures++; $display("[TB] FAIL min_pdm c=%0d: got %b expected %b", c, audio_pdm, m_pdm); end
      checks++; if (underrun !== m_under) begin failures++; $display("[TB] FAIL min_underrun c=%0d: got %b expected %b", c, underrun, m_under); end
      if (underrun === 1'b1) unders++;
      if (c >= 96 && audio_pdm === 1'b1) ones++;
    end
    checks++; if (unders != 0) begin failures++; $display("[TB] FAIL min_underrun_count: got %0d expected 0", unders); end
    checks++; if (ones != 0) begin failures++; $display("[TB] FAIL min_ones: got %0d expected 0", ones); end
    #1 sample_valid = 1'b0;
  endtask

  task automatic test_max_scale();
    logic bits[$];
    int ones;
    int readys;
    logic exp_ready;
    ones = 0; readys = 0;
    @(posedge clock);
    #1 reset = 1'b1; enable = 1'b1; sample_valid = 1'b1; sample_data = 16'h7FFF;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 96; c++) begin
      @(negedge clock);
      exp_ready = !reset && enable && (m_q.size() == 0);
      checks++; if (audio_pdm !== m_pdm) begin failures++; $display("[TB] FAIL max_pdm c=%0d: got %b expected %b", c, audio_pdm, m_pdm); end
      checks++; if (sample_ready !== exp_ready) begin failures++; $display("[TB] FAIL max_ready c=%0d: got %b expected %b", c, sample_ready, exp_ready); end
      if (m_tick) bits.push_back(audio_pdm);
      if (sample_ready === 1'b1) readys++;
    end
    for (int k = 8; k < 16; k++) if (bits[k] === 1'b1) ones++;
    checks++; if (bits[8] !== 1'b0) begin failures++; $display("[TB] FAIL max_first_bit: got %b expected 0", bits[8]); end
    checks++; if (ones != 7) begin failures++; $display("[TB] FAIL max_ones: got %0d expected 7", ones); end
    checks++; if (readys != 3) begin failures++; $display("[TB] FAIL max_ready_pulses: got %0d expected 3", readys); end
    #1 sample_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] seq [3];
    int at [3];
    int idx;
    logic take;
    logic exp_ready;
    seq[0] = 16'h1234; seq[1] = 16'h5678; seq[2] = 16'h9ABC;
    at[0] = -1; at[1] = -1; at[2] = -1;
    idx = 0;
    pulse_reset();
    sample_valid = 1'b1; sample_data = seq[0];
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      exp_ready = !reset && enable && (m_q.size() == 0);
      checks++; if (audio_pdm !== m_pdm) begin failures++; $display("[TB] FAIL b2b_pdm c=%0d: got %b expected %b", c, audio_pdm, m_pdm); end
      checks++; if (underrun !== m_under) begin failures++; $display("[TB] FAIL b2b_underrun c=%0d: got %b expected %b", c, underrun, m_under); end
      checks++; if (sample_ready !== exp_ready) begin failures++; $display("[TB] FAIL b2b_ready c=%0d: got %b expected %b", c, sample_ready, exp_ready); end
      take = sample_valid && sample_ready;
      @(posedge clock);
      #1;
      if (take) begin
        at[idx] = c;
        idx++;
        if (idx < 3) sample_data = seq[idx];
        else sample_valid = 1'b0;
      end
    end
    checks++; if (at[0] != 0) begin failures++; $display("[TB] FAIL b2b_accept0: got cycle %0d expected 0", at[0]); end
    checks++; if (at[1] != 32) begin failures++; $display("[TB] FAIL b2b_accept1: got cycle %0d expected 32", at[1]); end
    checks++; if (at[2] != 64) begin failures++; $display("[TB] FAIL b2b_accept2: got cycle %0d expected 64", at[2]); end
  endtask

  task automatic test_enable_drop();
    int nt;
    nt = 0;
    @(posedge clock);
    #1 reset = 1'b1; enable = 1'b1; sample_valid = 1'b1; sample_data = 16'h7FFF;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 42; c++) begin
      @(negedge clock);
      checks++; if (audio_pdm !== m_pdm) begin failures++; $display("[TB] FAIL drop_pre_pdm c=%0d: got %b expected %b", c, audio_pdm, m_pdm); end
    end
    @(posedge clock);
    #1 enable = 1'b0; sample_valid = 1'b0;
    @(negedge clock);
    checks++; if (sample_ready !== 1'b0) begin failures++; $display("[TB] FAIL drop_ready_now: got %b expected 0", sample_ready); end
    @(negedge clock);
    checks++; if (audio_sd !== 1'b0) begin failures++; $display("[TB] FAIL drop_sd: got %b expected 0", audio_sd); end
    checks++; if (audio_pdm !== 1'b0) begin failures++; $display("[TB] FAIL drop_pdm: got %b expected 0", audio_pdm); end
    checks++; if (pdm_clk !== 1'b0) begin failures++; $display("[TB] FAIL drop_pdm_clk: got %b expected 0", pdm_clk); end
    checks++; if (sample_ready !== 1'b0) begin failures++; $display("[TB] FAIL drop_ready: got %b expected 0", sample_ready); end
    repeat (2) @(posedge clock);
    #1 enable = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clock);
      checks++; if (audio_pdm !== m_pdm) begin failures++; $display("[TB] FAIL drop_post_pdm c=%0d: got %b expected %b", c, audio_pdm, m_pdm); end
      if (m_tick && nt < 16) begin
        checks++; if (audio_pdm !== nt[0]) begin failures++; $display("[TB] FAIL drop_flush tick=%0d: got %b expected %b", nt, audio_pdm, nt[0]); end
        nt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int nt;
    nt = 0;
    @(posedge clock);
    #1 reset = 1'b1; enable = 1'b1; sample_valid = 1'b1; sample_data = 16'h7FFF;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 54; c++) begin
      @(negedge clock);
      checks++; if (audio_pdm !== m_pdm) begin failures++; $display("[TB] FAIL rmid_pre_pdm c=%0d: got %b expected %b", c, audio_pdm, m_pdm); end
      if (c == 0) begin
        @(posedge clock);
        #1 sample_valid = 1'b0;
      end
    end
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++; if (audio_pdm !== 1'b0) begin failures++; $display("[TB] FAIL rmid_pdm: got %b expected 0", audio_pdm); end
    checks++; if (audio_sd !== 1'b0) begin failures++; $display("[TB] FAIL rmid_sd: got %b expected 0", audio_sd); end
    checks++; if (pdm_clk !== 1'b0) begin failures++; $display("[TB] FAIL rmid_pdm_clk: got %b expected 0", pdm_clk); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL rmid_underrun: got %b expected 0", underrun); end
    checks++; if (sample_ready !== 1'b0) begin failures++; $display("[TB] FAIL rmid_ready: got %b expected 0", sample_ready); end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      checks++; if (audio_pdm !== m_pdm) begin failures++; $display("[TB] FAIL rmid_post_pdm c=%0d: got %b expected %b", c, audio_pdm, m_pdm); end
      if (m_tick && nt < 8) begin
        checks++; if (audio_pdm !== nt[0]) begin failures++; $display("[TB] FAIL rmid_silence tick=%0d: got %b expected %b", nt, audio_pdm, nt[0]); end
        nt++;
      end
    end
  endtask

  task automatic test_random();
    logic exp_ready;
    pulse_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      exp_ready = !reset && enable && (m_q.size() == 0);
      checks++; if (audio_pdm !== m_pdm) begin failures++; $display("[TB] FAIL rand_pdm c=%0d: got %b expected %b", c, audio_pdm, m_pdm); end
      checks++; if (underrun !== m_under) begin failures++; $display("[TB] FAIL rand_underrun c=%0d: got %b expected %b", c, underrun, m_under); end
      checks++; if (sample_ready !== exp_ready) begin failures++; $display("[TB] FAIL rand_ready c=%0d: got %b expected %b", c, sample_ready, exp_ready); end
      checks++; if (audio_sd !== m_sd) begin failures++; $display("[TB] FAIL rand_sd c=%0d: got %b expected %b", c, audio_sd, m_sd); end
      @(posedge clock);
      #1;
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_data = W'($urandom);
      if (enable && $urandom_range(0, 149) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    $display("[TB] pdm_speaker bench start");
    test_reset();
    test_silence();
    test_min_scale();
    test_max_scale();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
